// File: rtl/item_store.sv
// item_store: vending item table with an init sweep, a vend FSM,
// a one-cycle item read port and a full-entry config port.
// Ports:
//   clk_fsm, rstn        clock, synchronous active-low reset
//   init_done, busy      table cleared / FSM not idle
//   fsm_read_*           item read: cost, stock, data_valid pulse
//   fsm_vend_*           vend: done pulse with ok and low_stock
//   cfg_*                entry read/write: rdata with ready pulse
module item_store #(
    parameter int NUM_ITEMS  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int COST_W     = 16,
    parameter int STOCK_W    = 8,
    parameter int SOLD_W     = 8,
    parameter int LOW_THRESH = 2
) (
    input  logic                              clk_fsm,
    input  logic                              rstn,
    output logic                              init_done,
    output logic                              busy,
    input  logic                              fsm_read_en,
    input  logic [ADDR_WIDTH-1:0]             fsm_read_addr,
    output logic [COST_W-1:0]                 fsm_item_cost,
    output logic [STOCK_W-1:0]                fsm_item_available,
    output logic                              fsm_data_valid,
    input  logic                              fsm_vend_en,
    input  logic [ADDR_WIDTH-1:0]             fsm_vend_addr,
    output logic                              fsm_vend_done,
    output logic                              fsm_vend_ok,
    output logic                              fsm_low_stock,
    input  logic                              cfg_en,
    input  logic                              cfg_we,
    input  logic [ADDR_WIDTH-1:0]             cfg_addr,
    input  logic [SOLD_W+STOCK_W+COST_W-1:0] cfg_wdata,
    output logic [SOLD_W+STOCK_W+COST_W-1:0] cfg_rdata,
    output logic                              cfg_ready
);

    localparam int ENTRY_W = SOLD_W + STOCK_W + COST_W;
    localparam int ST_LSB  = COST_W;
    localparam int SD_LSB  = COST_W + STOCK_W;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(NUM_ITEMS - 1);
    localparam logic [STOCK_W-1:0] THRESH = STOCK_W'(LOW_THRESH);
    localparam logic [SOLD_W-1:0] SOLD_MAX = {SOLD_W{1'b1}};

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_VEND_RD,
        S_VEND_WR
    } state_t;

    logic [ENTRY_W-1:0] mem_q [NUM_ITEMS];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic [ENTRY_W-1:0]    ent_q, ent_d;
    logic                  init_done_q, init_done_d;
    logic                  busy_q, busy_d;
    logic [COST_W-1:0]     cost_q, cost_d;
    logic [STOCK_W-1:0]    avail_q, avail_d;
    logic                  valid_q, valid_d;
    logic                  vdone_q, vdone_d;
    logic                  vok_q, vok_d;
    logic                  low_q, low_d;
    logic [ENTRY_W-1:0]    rdata_q, rdata_d;
    logic                  ready_q, ready_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [ENTRY_W-1:0]    mem_wdata;

    logic [COST_W-1:0]     ent_cost;
    logic [STOCK_W-1:0]    ent_stock;
    logic [SOLD_W-1:0]     ent_sold;
    logic [STOCK_W-1:0]    new_stock;
    logic [SOLD_W-1:0]     new_sold;
    logic                  vend_go, read_go, cfg_go;

    assign ent_cost  = ent_q[COST_W-1:0];
    assign ent_stock = ent_q[ST_LSB +: STOCK_W];
    assign ent_sold  = ent_q[SD_LSB +: SOLD_W];
    assign new_stock = ent_stock - STOCK_W'(1);
    assign new_sold  = (ent_sold == SOLD_MAX)
                     ? ent_sold : ent_sold + SOLD_W'(1);

    // A request is not re-granted in the cycle its own
    // completion pulse is visible; the requester drops it then.
    assign vend_go = fsm_vend_en && !vdone_q;
    assign read_go = fsm_read_en && !valid_q;
    assign cfg_go  = cfg_en && !ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vaddr_d     = vaddr_q;
        ent_d       = ent_q;
        init_done_d = init_done_q;
        cost_d      = cost_q;
        avail_d     = avail_q;
        valid_d     = 1'b0;
        vdone_d     = 1'b0;
        vok_d       = vok_q;
        low_d       = low_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q;
        mem_wdata   = '0;

        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_IDX) begin
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (vend_go) begin
                    vaddr_d = fsm_vend_addr;
                    state_d = S_VEND_RD;
                end else if (read_go) begin
                    cost_d  = mem_q[fsm_read_addr][COST_W-1:0];
                    avail_d = mem_q[fsm_read_addr][ST_LSB +: STOCK_W];
                    valid_d = 1'b1;
                end else if (cfg_go) begin
                    ready_d = 1'b1;
                    if (cfg_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = cfg_addr;
                        mem_wdata = cfg_wdata;
                    end else begin
                        rdata_d = mem_q[cfg_addr];
                    end
                end
            end
            S_VEND_RD: begin
                ent_d   = mem_q[vaddr_q];
                state_d = S_VEND_WR;
            end
            S_VEND_WR: begin
                state_d = S_IDLE;
                vdone_d = 1'b1;
                if (ent_stock == '0) begin
                    vok_d = 1'b0;
                    low_d = 1'b0;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = vaddr_q;
                    mem_wdata = {new_sold, new_stock, ent_cost};
                    vok_d     = 1'b1;
                    low_d     = (new_stock <= THRESH);
                end
            end
            default: state_d = S_INIT;
        endcase

        busy_d = (state_d != S_IDLE);

        // Reset wins over any pending write-back.
        if (!rstn) mem_we = 1'b0;
    end

    always_ff @(posedge clk_fsm) begin
        if (!rstn) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            vaddr_q     <= '0;
            ent_q       <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            cost_q      <= '0;
            avail_q     <= '0;
            valid_q     <= 1'b0;
            vdone_q     <= 1'b0;
            vok_q       <= 1'b0;
            low_q       <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vaddr_q     <= vaddr_d;
            ent_q       <= ent_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            cost_q      <= cost_d;
            avail_q     <= avail_d;
            valid_q     <= valid_d;
            vdone_q     <= vdone_d;
            vok_q       <= vok_d;
            low_q       <= low_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    // Table contents are not reset; the INIT sweep clears them.
    always_ff @(posedge clk_fsm) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign init_done          = init_done_q;
    assign busy               = busy_q;
    assign fsm_item_cost      = cost_q;
    assign fsm_item_available = avail_q;
    assign fsm_data_valid     = valid_q;
    assign fsm_vend_done      = vdone_q;
    assign fsm_vend_ok        = vok_q;
    assign fsm_low_stock      = low_q;
    assign cfg_rdata          = rdata_q;
    assign cfg_ready          = ready_q;

endmodule
